// File: rtl/mod_exp_seq.sv
// Sequential modular exponentiator: base^exp mod N by left-to-right square-and-multiply
// on a single bit-serial interleaved modular multiplier, with start/busy/done handshake.
module mod_exp_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exp,
  input  logic [WIDTH-1:0] mod,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] TOP = CW'(WIDTH - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RED  = 3'd1;
  localparam logic [2:0] S_SQR  = 3'd2;
  localparam logic [2:0] S_MUL  = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] mod_q, mod_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [CW-1:0]    bit_q, bit_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic             err_pend_q, err_pend_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] mm_a, mm_b, mm_p;
  logic [WIDTH:0]   n_ext, dbl, acc;
  logic             last_bit;

  // One multiplier iteration: P = 2P mod N, then conditionally P = (P + A) mod N.
  // Temporaries are one bit wider than the operands so neither step can overflow.
  // NOTE: blocking assignments are correct here because this is combinational;
  // every variable is given a default first so no latch is inferred.
  always_comb begin
    mm_a = r_q;
    mm_b = x_q;
    case (state_q)
      S_RED: begin
        mm_a = WIDTH'(1);
        mm_b = base_q;
      end
      S_SQR: mm_b = r_q;
      default: ;
    endcase

    n_ext = {1'b0, mod_q};
    dbl   = {p_q, 1'b0};
    if (dbl >= n_ext) dbl = dbl - n_ext;
    acc = dbl;
    if (mm_b[bit_q]) begin
      acc = dbl + {1'b0, mm_a};
      if (acc >= n_ext) acc = acc - n_ext;
    end
    mm_p     = acc[WIDTH-1:0];
    last_bit = (bit_q == '0);
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    exp_d      = exp_q;
    mod_d      = mod_q;
    x_d        = x_q;
    r_d        = r_q;
    p_d        = p_q;
    bit_d      = bit_q;
    idx_d      = idx_q;
    err_pend_d = err_pend_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    result_d   = result_q;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d = base;
          exp_d  = exp;
          mod_d  = mod;
          busy_d = 1'b1;
          if (mod < WIDTH'(2)) begin
            err_pend_d = 1'b1;
            state_d    = S_FIN;
          end else begin
            err_pend_d = 1'b0;
            r_d        = WIDTH'(1);
            p_d        = '0;
            bit_d      = TOP;
            idx_d      = TOP;
            state_d    = S_RED;
          end
        end
      end

      S_RED, S_SQR, S_MUL: begin
        p_d   = mm_p;
        bit_d = bit_q - 1'b1;
        if (last_bit) begin
          p_d   = '0;
          bit_d = TOP;
          if (state_q == S_RED) begin
            x_d     = mm_p;
            state_d = S_SQR;
          end else begin
            r_d = mm_p;
            if (state_q == S_SQR && exp_q[idx_q]) begin
              state_d = S_MUL;
            end else if (idx_q == '0) begin
              state_d = S_FIN;
            end else begin
              idx_d   = idx_q - 1'b1;
              state_d = S_SQR;
            end
          end
        end
      end

      S_FIN: begin
        result_d = err_pend_q ? '0 : r_q;
        err_d    = err_pend_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; all registers, including operand latches, are reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      exp_q      <= '0;
      mod_q      <= '0;
      x_q        <= '0;
      r_q        <= '0;
      p_q        <= '0;
      bit_q      <= '0;
      idx_q      <= '0;
      err_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      exp_q      <= exp_d;
      mod_q      <= mod_d;
      x_q        <= x_d;
      r_q        <= r_d;
      p_q        <= p_d;
      bit_q      <= bit_d;
      idx_q      <= idx_d;
      err_pend_q <= err_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      err_q      <= err_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign err    = err_q;

endmodule

// File: tb/tb_mod_exp_seq.sv
// Directed bench for mod_exp_seq: hand-computed results and latencies for WIDTH=8
// plus one WIDTH=32 vector, handshake corner cases and asynchronous reset.
module tb_mod_exp_seq;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic [7:0] base_i, exp_i, mod_i;
  logic       busy, done, err;
  logic [7:0] result;

  logic        start32;
  logic [31:0] base32, exp32, mod32;
  logic        busy32, done32, err32;
  logic [31:0] result32;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mod_exp_seq #(.WIDTH(8)) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .base(base_i), .exp(exp_i), .mod(mod_i),
    .busy(busy), .done(done), .result(result), .err(err)
  );

  mod_exp_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .rstn(rstn), .start(start32),
    .base(base32), .exp(exp32), .mod(mod32),
    .busy(busy32), .done(done32), .result(result32), .err(err32)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Issue one op; if poke >= 0, pulse start with other operands that many cycles in.
  task automatic run_op(input string tag, input logic [7:0] b, input logic [7:0] e,
                        input logic [7:0] m, input logic [7:0] exp_res,
                        input logic exp_err, input int exp_lat, input int poke);
    int  cnt;
    logic got;
    @(negedge clk);
    base_i = b; exp_i = e; mod_i = m; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({tag, " busy_after_start"}, 64'(busy), 64'd1);
    cnt = 0;
    got = 1'b0;
    while (!got && cnt < 2000) begin
      if (cnt == poke) begin
        start = 1'b1; base_i = ~b; exp_i = 8'h07; mod_i = 8'h0B;
      end
      @(posedge clk);
      cnt++;
      #1 start = 1'b0;
      got = done;
    end
    check({tag, " latency"}, 64'(cnt), 64'(exp_lat));
    check({tag, " result"}, 64'(result), 64'(exp_res));
    check({tag, " err"}, 64'(err), 64'(exp_err));
    check({tag, " busy_at_done"}, 64'(busy), 64'd0);
    @(posedge clk);
    #1 check({tag, " done_one_cycle"}, 64'(done), 64'd0);
  endtask

  initial begin
    int cnt;
    logic got;
    rstn = 1'b0; start = 1'b0; base_i = '0; exp_i = '0; mod_i = '0;
    start32 = 1'b0; base32 = '0; exp32 = '0; mod32 = '0;
    #12;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset result", 64'(result), 64'd0);
    check("reset err", 64'(err), 64'd0);
    @(negedge clk);
    rstn = 1'b1;

    run_op("4^13%251", 8'd4, 8'd13, 8'd251, 8'd249, 1'b0, 97, -1);
    run_op("200^3%7", 8'd200, 8'd3, 8'd7, 8'd1, 1'b0, 89, -1);
    run_op("255^255%254", 8'd255, 8'd255, 8'd254, 8'd1, 1'b0, 137, -1);
    run_op("5^0%13", 8'd5, 8'd0, 8'd13, 8'd1, 1'b0, 73, -1);
    run_op("7^3%10", 8'd7, 8'd3, 8'd10, 8'd3, 1'b0, 89, -1);
    run_op("0^5%13", 8'd0, 8'd5, 8'd13, 8'd0, 1'b0, 89, -1);
    run_op("mod1", 8'd9, 8'd3, 8'd1, 8'd0, 1'b1, 1, -1);
    run_op("mod0", 8'd9, 8'd3, 8'd0, 8'd0, 1'b1, 1, -1);
    run_op("10^1%13", 8'd10, 8'd1, 8'd13, 8'd10, 1'b0, 81, -1);
    run_op("ignore_mid_start", 8'd4, 8'd13, 8'd251, 8'd249, 1'b0, 97, 20);

    // Start held high through done: second op accepted in the done cycle.
    @(negedge clk);
    base_i = 8'd200; exp_i = 8'd3; mod_i = 8'd7; start = 1'b1;
    @(posedge clk);
    #1 base_i = 8'd10; exp_i = 8'd1; mod_i = 8'd13;
    cnt = 0; got = 1'b0;
    while (!got && cnt < 2000) begin
      @(posedge clk);
      cnt++;
      #1 got = done;
    end
    check("held first latency", 64'(cnt), 64'd89);
    check("held first result", 64'(result), 64'd1);
    @(posedge clk);
    #1 start = 1'b0;
    check("held second busy", 64'(busy), 64'd1);
    cnt = 0; got = 1'b0;
    while (!got && cnt < 2000) begin
      @(posedge clk);
      cnt++;
      #1 got = done;
    end
    check("held second latency", 64'(cnt), 64'd81);
    check("held second result", 64'(result), 64'd10);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    base_i = 8'd4; exp_i = 8'd13; mod_i = 8'd251; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (30) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst result", 64'(result), 64'd0);
    got = 1'b0;
    repeat (5) begin
      @(negedge clk);
      got = got | done;
    end
    rstn = 1'b1;
    repeat (100) begin
      @(negedge clk);
      got = got | done;
    end
    check("rst no_done", 64'(got), 64'd0);
    run_op("after_rst", 8'd4, 8'd13, 8'd251, 8'd249, 1'b0, 97, -1);

    // WIDTH=32: 3^5 mod 100 = 243 mod 100 = 43; L = 32*(1+32+2)+1.
    @(negedge clk);
    base32 = 32'd3; exp32 = 32'd5; mod32 = 32'd100; start32 = 1'b1;
    @(posedge clk);
    #1 start32 = 1'b0;
    cnt = 0; got = 1'b0;
    while (!got && cnt < 5000) begin
      @(posedge clk);
      cnt++;
      #1 got = done32;
    end
    check("w32 latency", 64'(cnt), 64'd1121);
    check("w32 result", 64'(result32), 64'd43);
    check("w32 err", 64'(err32), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
